vdc_ram_arbiter: RTL and testbench

Single-port video RAM arbiter sitting directly upstream of the VTL video chip. It merges the chip's periodic character/bitmap fetches with Z80 CPU reads and writes into one 16 KB synchronous RAM port. Video fetches always win. The CPU is stalled through a WAIT-style handshake until its access completes. It replaces the video chip's simulated `ramQ` source with real RAM data.

---
 rtl/vdc_pkg.sv | 12 +
 rtl/vdc_wbuf.sv | 31 +++
 rtl/vdc_ram_arbiter.sv | 121 ++++++++++++
 tb/tb_vdc_ram_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdc_pkg.sv
// Shared types and sizes for the VTL video RAM arbiter.
package vdc_pkg;
  localparam int VRAM_AW = 14;
  localparam int VRAM_DW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } cpu_state_t;
endpackage

// File: rtl/vdc_wbuf.sv
// One-entry posted CPU write buffer; holds a write until a free RAM slot drains it.
module vdc_wbuf
  import vdc_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          drain,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          full,
  output logic [AW-1:0] buf_addr,
  output logic [DW-1:0] buf_wdata
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
    end else if (load) begin
      full      <= 1'b1;
      buf_addr  <= addr;
      buf_wdata <= wdata;
    end else if (drain) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/vdc_ram_arbiter.sv
// Video/CPU arbiter for the single-port 16 KB video RAM; video fetches always win.
// Define VDC_WRITE_BUFFER_EN to post CPU writes through a 1-entry buffer.
module vdc_ram_arbiter
  import vdc_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW
) (
  input  logic          F14M,
  input  logic          RESET_N,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_wait,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_q
);
  localparam int VID_STAGES = 1;

  cpu_state_t          state;
  logic [VID_STAGES:0] vld_pipe;
  logic                cpu_go;
  logic                cpu_post;

`ifdef VDC_WRITE_BUFFER_EN
  logic          wb_full;
  logic          wb_drain;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_wdata;

  // Writes never touch the port from the FSM; reads wait behind a full buffer.
  assign cpu_post = (state == IDLE) && cpu_req && cpu_wr && !wb_full;
  assign wb_drain = wb_full && !vid_req;
  assign cpu_go   = (state == IDLE) && cpu_req && !cpu_wr && !wb_full && !vid_req;

  vdc_wbuf #(.AW(AW), .DW(DW)) u_wbuf (
    .clk       (F14M),
    .rst_n     (RESET_N),
    .load      (cpu_post),
    .drain     (wb_drain),
    .addr      (cpu_addr),
    .wdata     (cpu_wdata),
    .full      (wb_full),
    .buf_addr  (wb_addr),
    .buf_wdata (wb_wdata)
  );
`else
  assign cpu_post = 1'b0;
  assign cpu_go   = (state == IDLE) && cpu_req && !vid_req;
`endif

  assign cpu_wait = cpu_req && (state != DONE);

  always_ff @(posedge F14M or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      cpu_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_post)    state <= DONE;
          else if (cpu_go) state <= ISSUE;
        end
        ISSUE:  state <= cpu_wr ? DONE : RDWAIT;
        RDWAIT: begin
          cpu_rdata <= ram_q;
          state     <= DONE;
        end
        DONE:    if (!cpu_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // One access per edge: video, then buffered write, then CPU.
  always_ff @(posedge F14M or negedge RESET_N) begin
    if (!RESET_N) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      ram_we <= 1'b0;
      if (vid_req) begin
        ram_addr <= vid_addr;
      end
`ifdef VDC_WRITE_BUFFER_EN
      else if (wb_drain) begin
        ram_addr  <= wb_addr;
        ram_we    <= 1'b1;
        ram_wdata <= wb_wdata;
      end
`endif
      else if (cpu_go) begin
        ram_addr  <= cpu_addr;
        ram_we    <= cpu_wr;
        ram_wdata <= cpu_wdata;
      end
    end
  end

  // Tag pipeline: a video read issued at E0 returns on ram_q after E1.
  always_ff @(posedge F14M or negedge RESET_N) begin
    if (!RESET_N) begin
      vld_pipe  <= '0;
      vid_valid <= 1'b0;
      vid_data  <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[VID_STAGES-1:0], vid_req};
      vid_valid <= vld_pipe[VID_STAGES];
      if (vld_pipe[VID_STAGES]) vid_data <= ram_q;
    end
  end
endmodule

// File: tb/tb_vdc_ram_arbiter.sv
// Randomized self-checking bench for vdc_ram_arbiter with a behavioural RAM and reference memory.
module tb_vdc_ram_arbiter;
`ifdef VDC_WRITE_BUFFER_EN
  localparam int WR_WAIT = 1;
  localparam bit BUFFERED = 1'b1;
`else
  localparam int WR_WAIT = 2;
  localparam bit BUFFERED = 1'b0;
`endif

  logic        F14M = 1'b0;
  logic        RESET_N = 1'b0;
  logic        vid_req = 1'b0;
  logic [13:0] vid_addr = '0;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        cpu_req = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [13:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_wait;
  logic [13:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_q;

  logic [7:0] mem     [0:16383];
  logic [7:0] ref_mem [0:16383];
  logic [7:0] exp_vq[$];
  int         exp_vc[$];
  int         cyc = 0;
  int         we_cnt = 0;
  int         checks = 0;
  int         errors = 0;

  vdc_ram_arbiter dut (
    .F14M(F14M), .RESET_N(RESET_N),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q)
  );

  always #5 F14M = ~F14M;

  // Synchronous single-port RAM seen by the arbiter
  always @(posedge F14M) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
    cyc   <= cyc + 1;
  end

  // Every vid_valid pulse must match the oldest outstanding fetch in data and arrival cycle
  always @(negedge F14M) begin
    if (ram_we) we_cnt = we_cnt + 1;
    if (vid_valid) begin
      checks = checks + 1;
      if (exp_vq.size() == 0) begin
        errors = errors + 1;
        $display("FAIL vid_unexpected data=%h cyc=%0d", vid_data, cyc);
      end else begin
        logic [7:0] ed;
        int ec;
        ed = exp_vq.pop_front();
        ec = exp_vc.pop_front();
        if (vid_data !== ed || cyc != ec) begin
          errors = errors + 1;
          $display("FAIL vid_fetch data=%h cyc=%0d expected data=%h cyc=%0d", vid_data, cyc, ed, ec);
        end
      end
    end
  end

  task automatic step();
    @(posedge F14M);
    #1;
  endtask

  task automatic issue_vid(input logic [13:0] va);
    vid_req  = 1'b1;
    vid_addr = va;
    exp_vq.push_back(ref_mem[va]);
    exp_vc.push_back(cyc + 3);
  endtask

  // One complete CPU handshake; returns the number of cycles cpu_wait was high
  task automatic cpu_access(input logic wr, input logic [13:0] a, input logic [7:0] d,
                            input logic collide, input logic [13:0] va,
                            output int waits, output logic [7:0] rd);
    waits     = 0;
    cpu_req   = 1'b1;
    cpu_wr    = wr;
    cpu_addr  = a;
    cpu_wdata = d;
    if (collide) issue_vid(va);
    #1;
    while (cpu_wait && waits < 20) begin
      waits = waits + 1;
      @(posedge F14M);
      #1;
      vid_req = 1'b0;
      #1;
    end
    rd      = cpu_rdata;
    cpu_req = 1'b0;
    vid_req = 1'b0;
    step();
    if (wr) ref_mem[a] = d;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    cpu_req = 1'b1;
    repeat (3) step();
    checks = checks + 1;
    if (cpu_wait !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL reset_wait_req got=%b expected=1", cpu_wait);
    end
    cpu_req = 1'b0;
    #1;
    checks = checks + 1;
    if ({vid_data, vid_valid, cpu_rdata, ram_addr, ram_we, ram_wdata, cpu_wait} !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs vd=%h vv=%b rd=%h ra=%h we=%b wd=%h wait=%b expected all 0",
               vid_data, vid_valid, cpu_rdata, ram_addr, ram_we, ram_wdata, cpu_wait);
    end
    RESET_N = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_video_fetch();
    logic [2:0] vv;
    mem[14'h3800]     = 8'h41;
    ref_mem[14'h3800] = 8'h41;
    issue_vid(14'h3800);
    step();
    vid_req = 1'b0;
    vv[0] = vid_valid;
    step();
    vv[1] = vid_valid;
    step();
    vv[2] = vid_valid;
    checks = checks + 1;
    if (vv !== 3'b100 || vid_data !== 8'h41) begin
      errors = errors + 1;
      $display("FAIL vid_latency valid_seq=%b data=%h expected 100 data=41", vv, vid_data);
    end
    repeat (5) step();
    for (int i = 0; i < 6; i++) begin
      issue_vid(14'h3000 + 14'($urandom_range(0, 14'hFFF)));
      step();
      vid_req = 1'b0;
      repeat (7) step();
    end
    checks = checks + 1;
    if (exp_vq.size() != 0) begin
      errors = errors + 1;
      $display("FAIL vid_outstanding got=%0d expected=0", exp_vq.size());
    end
  endtask

  task automatic test_cpu_read();
    int w;
    logic [7:0] rd;
    mem[14'h0123]     = 8'h5A;
    ref_mem[14'h0123] = 8'h5A;
    cpu_access(1'b0, 14'h0123, 8'h00, 1'b0, '0, w, rd);
    checks = checks + 1;
    if (w != 3 || rd !== 8'h5A) begin
      errors = errors + 1;
      $display("FAIL cpu_read waits=%0d data=%h expected waits=3 data=5a", w, rd);
    end
    repeat (4) step();
  endtask

  task automatic test_collision();
    int w;
    logic [7:0] rd;
    logic [13:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 14'($urandom_range(0, 14'h1FFF));
      cpu_access(1'b0, a, 8'h00, 1'b1, 14'h3000 + 14'($urandom_range(0, 14'hFFF)), w, rd);
      checks = checks + 1;
      if (w != 4 || rd !== ref_mem[a]) begin
        errors = errors + 1;
        $display("FAIL collision_read waits=%0d data=%h expected waits=4 data=%h", w, rd, ref_mem[a]);
      end
      repeat (6) step();
    end
    checks = checks + 1;
    if (exp_vq.size() != 0) begin
      errors = errors + 1;
      $display("FAIL collision_vid_outstanding got=%0d expected=0", exp_vq.size());
    end
  endtask

  task automatic test_cpu_write();
    int w, we0;
    logic [7:0] rd;
    we0 = we_cnt;
    cpu_access(1'b1, 14'h2000, 8'hC3, 1'b0, '0, w, rd);
    repeat (4) step();
    checks = checks + 1;
    if (w != WR_WAIT || (we_cnt - we0) != 1) begin
      errors = errors + 1;
      $display("FAIL cpu_write waits=%0d we_pulses=%0d expected waits=%0d we_pulses=1",
               w, we_cnt - we0, WR_WAIT);
    end
    issue_vid(14'h2000);
    step();
    vid_req = 1'b0;
    repeat (3) step();
    checks = checks + 1;
    if (vid_data !== 8'hC3) begin
      errors = errors + 1;
      $display("FAIL write_then_fetch got=%h expected=c3", vid_data);
    end
    repeat (4) step();
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    logic [7:0] rd, d;
    logic [13:0] a;
    for (int i = 0; i < 6; i++) begin
      a = 14'($urandom_range(0, 14'h1FFF));
      d = 8'($urandom);
      cpu_access(1'b1, a, d, 1'b0, '0, w1, rd);
      cpu_access(1'b0, a, 8'h00, 1'b0, '0, w2, rd);
      checks = checks + 1;
      if (w1 != WR_WAIT || w2 != 3 || rd !== d) begin
        errors = errors + 1;
        $display("FAIL back_to_back wr_waits=%0d rd_waits=%0d data=%h expected %0d 3 %h",
                 w1, w2, rd, WR_WAIT, d);
      end
    end
    repeat (4) step();
  endtask

  task automatic test_random_mix();
    int w, ew;
    logic [7:0] rd, d;
    logic [13:0] a;
    logic wr, col;
    for (int i = 0; i < 24; i++) begin
      wr  = 1'($urandom);
      col = 1'($urandom);
      a   = 14'($urandom_range(0, 14'h1FFF));
      d   = 8'($urandom);
      ew  = wr ? (BUFFERED ? 1 : 2 + int'(col)) : 3 + int'(col);
      cpu_access(wr, a, d, col, 14'h3000 + 14'($urandom_range(0, 14'hFFF)), w, rd);
      checks = checks + 1;
      if (w != ew || (!wr && rd !== ref_mem[a])) begin
        errors = errors + 1;
        $display("FAIL random_op%0d wr=%b col=%b waits=%0d data=%h expected waits=%0d data=%h",
                 i, wr, col, w, rd, ew, ref_mem[a]);
      end
      repeat (5) step();
    end
  endtask

  task automatic test_reset_mid();
    int w;
    logic [7:0] rd;
    cpu_req  = 1'b1;
    cpu_wr   = 1'b0;
    cpu_addr = 14'h0ABC;
    step();
    step();
    RESET_N = 1'b0;
    cpu_req = 1'b0;
    #1;
    checks = checks + 1;
    if ({vid_data, vid_valid, cpu_rdata, ram_addr, ram_we, ram_wdata, cpu_wait} !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_mid_outputs vd=%h vv=%b rd=%h ra=%h we=%b wd=%h wait=%b expected all 0",
               vid_data, vid_valid, cpu_rdata, ram_addr, ram_we, ram_wdata, cpu_wait);
    end
    repeat (2) step();
    RESET_N = 1'b1;
    step();
    cpu_access(1'b0, 14'h0ABC, 8'h00, 1'b0, '0, w, rd);
    checks = checks + 1;
    if (w != 3 || rd !== ref_mem[14'h0ABC]) begin
      errors = errors + 1;
      $display("FAIL reset_recover waits=%0d data=%h expected waits=3 data=%h", w, rd, ref_mem[14'h0ABC]);
    end
    repeat (4) step();
`ifdef VDC_WRITE_BUFFER_EN
    cpu_req   = 1'b1;
    cpu_wr    = 1'b1;
    cpu_addr  = 14'h0555;
    cpu_wdata = ~ref_mem[14'h0555];
    step();
    RESET_N = 1'b0;
    cpu_req = 1'b0;
    repeat (2) step();
    RESET_N = 1'b1;
    repeat (4) step();
    checks = checks + 1;
    if (mem[14'h0555] !== ref_mem[14'h0555]) begin
      errors = errors + 1;
      $display("FAIL wbuf_discard ram=%h expected=%h", mem[14'h0555], ref_mem[14'h0555]);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_video_fetch();
    test_cpu_read();
    test_collision();
    test_cpu_write();
    test_back_to_back();
    test_random_mix();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end
endmodule
